// File: rtl/jtag_vector_mem_if.sv
// ---------------------------------------------------------------------------
// jtag_vector_mem_if
// Avalon-MM slave bus bundle for jtag_vector_mem.
//   address        Avalon word address (ADDR_W bits)
//   chipselect     transfer qualifier
//   read / write   transfer type
//   byteenable     byte-lane enables for writes
//   writedata      write data
//   readdata       read data, valid while readdatavalid is high
//   readdatavalid  single-cycle pulse one clock after an accepted read
// The master modport is the bus host (CPU / testbench); the slave modport is
// the register/vector memory block.
// ---------------------------------------------------------------------------
interface jtag_vector_mem_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/jtag_vector_mem.sv
// ---------------------------------------------------------------------------
// jtag_vector_mem
// Avalon-MM slave holding the JTAG calibration/config register file, NUM_CH
// byte-lane vector banks and a 32-bit ADC capture bank, plus a sequencer that
// streams one byte per channel from VEC_START..VEC_END for VEC_REPEAT passes.
//
// Ports
//   clk, reset_n         single clock, asynchronous active-low reset
//   avs                  Avalon-MM slave bus (jtag_vector_mem_if.slave)
//   tck_width .. adc_config_even   32-bit register-file outputs
//   seq_valid/seq_ready  sequencer beat handshake
//   seq_data             one byte per channel, ch k at [8k+7:8k]
//   seq_last             beat is the final byte of the final pass
//   adc_we/adc_addr/adc_wr_data   ADC capture write port
//   irq                  (only with JVM_IRQ_EN) registered done | err
//
// Configuration macro: JVM_IRQ_EN adds the irq output.
//
// Address map: region = address[ADDR_W-1:BANK_AW]
//   0 registers, 1..NUM_CH vector banks, NUM_CH+1 ADC bank,
//   anything else reads 32'hDEADBEEF and ignores writes.
// ---------------------------------------------------------------------------
module jtag_vector_mem #(
  parameter int NUM_CH  = 2,
  parameter int BANK_AW = 10,
  parameter int ADDR_W  = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  jtag_vector_mem_if.slave      avs,
  output logic [31:0]           tck_width,
  output logic [31:0]           tck_delay,
  output logic [31:0]           tms_delay,
  output logic [31:0]           tdi_delay,
  output logic [31:0]           tdo_delay,
  output logic [31:0]           adc_start_delay,
  output logic [31:0]           adc_config_odd,
  output logic [31:0]           adc_config_even,
  output logic                  seq_valid,
  input  logic                  seq_ready,
  output logic [8*NUM_CH-1:0]   seq_data,
  output logic                  seq_last,
  input  logic                  adc_we,
  input  logic [BANK_AW-1:0]    adc_addr,
  input  logic [31:0]           adc_wr_data
`ifdef JVM_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int          RGN_W    = ADDR_W - BANK_AW;
  localparam int          DEPTH    = 2 ** BANK_AW;
  localparam int          BA_W     = BANK_AW + 2;
  localparam logic [31:0] BA_LIMIT = 32'(1) << BA_W;
  localparam logic [31:0] ID_VALUE = 32'h4A564D02;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // Bus decode
  logic [RGN_W-1:0]   region;
  logic [BANK_AW-1:0] word;
  logic               wr_acc, rd_acc;
  logic               rgn_regs, rgn_vec, rgn_adc;
  logic               ctrl_wr, start, abort, clear;

  assign region   = avs.address[ADDR_W-1:BANK_AW];
  assign word     = avs.address[BANK_AW-1:0];
  assign wr_acc   = avs.chipselect & avs.write;
  assign rd_acc   = avs.chipselect & avs.read;
  assign rgn_regs = (region == '0);
  assign rgn_vec  = (region != '0) && (region <= RGN_W'(NUM_CH));
  assign rgn_adc  = (region == RGN_W'(NUM_CH + 1));

  // CTRL bits live in byte lane 0, so that lane must be enabled to pulse them.
  assign ctrl_wr = wr_acc & rgn_regs & (word[3:0] == 4'd11) & avs.byteenable[0];
  assign start   = ctrl_wr & avs.writedata[0];
  assign abort   = ctrl_wr & avs.writedata[1];
  assign clear   = ctrl_wr & avs.writedata[2];

  // Storage and state
  logic [31:0]        cfg_q [11];
  logic [31:0]        vmem  [NUM_CH][DEPTH];
  logic [31:0]        amem  [DEPTH];
  state_t             state_q;
  logic [BA_W-1:0]    cur_addr_q, vstart_q, vend_q;
  logic [31:0]        cur_pass_q, vrep_q;
  logic               done_q, err_q, done_d, err_d;
  logic               seq_valid_q, seq_last_q;
  logic [8*NUM_CH-1:0] seq_data_q, seq_bytes;
  logic [31:0]        readdata_q, rd_d;
  logic               readdatavalid_q;

  // Read-write config registers 0..10, each byte lane written independently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 11; r++) cfg_q[r] <= '0;
    end else if (wr_acc && rgn_regs && (word[3:0] <= 4'd10)) begin
      for (int b = 0; b < 4; b++)
        if (avs.byteenable[b]) cfg_q[word[3:0]][8*b +: 8] <= avs.writedata[8*b +: 8];
    end
  end

  // Vector banks: CPU byte-masked writes only; contents are not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (wr_acc && (region == RGN_W'(c + 1)))
        for (int b = 0; b < 4; b++)
          if (avs.byteenable[b]) vmem[c][word][8*b +: 8] <= avs.writedata[8*b +: 8];
  end

  // ADC bank: the capture port owns a word when it collides with a CPU write.
  always_ff @(posedge clk) begin
    if (adc_we) amem[adc_addr] <= adc_wr_data;
    if (wr_acc && rgn_adc && !(adc_we && (adc_addr == word)))
      for (int b = 0; b < 4; b++)
        if (avs.byteenable[b]) amem[word][8*b +: 8] <= avs.writedata[8*b +: 8];
  end

  // Read data mux feeding the single read-latency register.
  always_comb begin
    rd_d = 32'hDEADBEEF;
    if (rgn_regs) begin
      case (word[3:0])
        4'd11:   rd_d = '0;
        4'd12:   rd_d = {29'd0, err_q, done_q, (state_q == ST_RUN)};
        4'd13:   rd_d = 32'(cur_addr_q);
        4'd14:   rd_d = cur_pass_q;
        4'd15:   rd_d = ID_VALUE;
        default: rd_d = cfg_q[word[3:0]];
      endcase
    end else if (rgn_vec) begin
      for (int c = 0; c < NUM_CH; c++)
        if (region == RGN_W'(c + 1)) rd_d = vmem[c][word];
    end else if (rgn_adc) begin
      rd_d = amem[word];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= rd_acc;
      if (rd_acc) readdata_q <= rd_d;
    end
  end

  // Byte at CUR_ADDR from every bank, gathered into one beat.
  always_comb begin
    logic [31:0] w;
    seq_bytes = '0;
    w         = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w = vmem[c][cur_addr_q[BA_W-1:2]];
      seq_bytes[8*c +: 8] = w[8*cur_addr_q[1:0] +: 8];
    end
  end

  logic        range_ok, issue, last_hit, final_acc;
  logic [31:0] rep_eff;

  assign range_ok  = (cfg_q[8] <= cfg_q[9]) && (cfg_q[9] < BA_LIMIT);
  assign issue     = (state_q == ST_RUN) && (!seq_valid_q || seq_ready);
  assign rep_eff   = (vrep_q == '0) ? 32'd1 : vrep_q;
  assign last_hit  = (cur_addr_q == vend_q) &&
                     (({1'b0, cur_pass_q} + 33'd1) >= {1'b0, rep_eff});
  assign final_acc = (state_q == ST_DONE) && seq_valid_q && seq_ready && !abort;

  // Sticky status flags: clear first, so a same-cycle set still lands.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (final_acc) done_d = 1'b1;
    if (start && !abort && (state_q == ST_IDLE) && !range_ok) err_d = 1'b1;
  end

  // Sequencer FSM. Abort overrides everything and drops any pending beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      cur_pass_q  <= '0;
      vstart_q    <= '0;
      vend_q      <= '0;
      vrep_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
      seq_data_q  <= '0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (abort) begin
        state_q     <= ST_IDLE;
        seq_valid_q <= 1'b0;
        seq_last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && range_ok) begin
              state_q    <= ST_RUN;
              cur_addr_q <= cfg_q[8][BA_W-1:0];
              cur_pass_q <= '0;
              vstart_q   <= cfg_q[8][BA_W-1:0];
              vend_q     <= cfg_q[9][BA_W-1:0];
              vrep_q     <= cfg_q[10];
            end
          end
          ST_RUN: begin
            if (issue) begin
              seq_valid_q <= 1'b1;
              seq_data_q  <= seq_bytes;
              seq_last_q  <= last_hit;
              if (last_hit) begin
                state_q <= ST_DONE;
              end else if (cur_addr_q == vend_q) begin
                cur_addr_q <= vstart_q;
                cur_pass_q <= cur_pass_q + 32'd1;
              end else begin
                cur_addr_q <= cur_addr_q + BA_W'(1);
              end
            end
          end
          ST_DONE: begin
            if (seq_valid_q && seq_ready) begin
              seq_valid_q <= 1'b0;
              seq_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef JVM_IRQ_EN
  logic irq_q;

  // Interrupt tracks the next-state status flags so it moves with STATUS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= done_d | err_d;
  end

  assign irq = irq_q;
`endif

  assign avs.readdata      = readdata_q;
  assign avs.readdatavalid = readdatavalid_q;
  assign seq_valid         = seq_valid_q;
  assign seq_data          = seq_data_q;
  assign seq_last          = seq_last_q;
  assign tck_width         = cfg_q[0];
  assign tck_delay         = cfg_q[1];
  assign tms_delay         = cfg_q[2];
  assign tdi_delay         = cfg_q[3];
  assign tdo_delay         = cfg_q[4];
  assign adc_start_delay   = cfg_q[5];
  assign adc_config_odd    = cfg_q[6];
  assign adc_config_even   = cfg_q[7];

endmodule

// File: tb/tb_jtag_vector_mem.sv
// ---------------------------------------------------------------------------
// tb_jtag_vector_mem
// Self-checking bench for jtag_vector_mem: register file, vector banks,
// sequencer streaming (with and without back-pressure), illegal range,
// abort, and ADC write collision. Sequencer beats are predicted from a byte
// model of the vector banks and queued, then popped as the DUT hands them off.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtag_vector_mem;
  localparam int NUM_CH  = 2;
  localparam int BANK_AW = 10;
  localparam int ADDR_W  = 13;

  typedef struct packed {
    logic [8*NUM_CH-1:0] data;
    logic                last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  jtag_vector_mem_if #(.ADDR_W(ADDR_W)) avs ();

  logic [31:0]         tck_width, tck_delay, tms_delay, tdi_delay, tdo_delay;
  logic [31:0]         adc_start_delay, adc_config_odd, adc_config_even;
  logic                seq_valid, seq_ready, seq_last;
  logic [8*NUM_CH-1:0] seq_data;
  logic                adc_we;
  logic [BANK_AW-1:0]  adc_addr;
  logic [31:0]         adc_wr_data;
`ifdef JVM_IRQ_EN
  logic                irq;
`endif

  jtag_vector_mem #(.NUM_CH(NUM_CH), .BANK_AW(BANK_AW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .avs(avs),
    .tck_width(tck_width), .tck_delay(tck_delay), .tms_delay(tms_delay),
    .tdi_delay(tdi_delay), .tdo_delay(tdo_delay), .adc_start_delay(adc_start_delay),
    .adc_config_odd(adc_config_odd), .adc_config_even(adc_config_even),
    .seq_valid(seq_valid), .seq_ready(seq_ready), .seq_data(seq_data), .seq_last(seq_last),
    .adc_we(adc_we), .adc_addr(adc_addr), .adc_wr_data(adc_wr_data)
`ifdef JVM_IRQ_EN
    , .irq(irq)
`endif
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  beat_t       exp_q[$];
  logic [7:0]  model [NUM_CH][4096];

  function automatic logic [ADDR_W-1:0] reg_addr(input int r);
    return ADDR_W'(r);
  endfunction

  function automatic logic [ADDR_W-1:0] bank_addr(input int ch, input int w);
    return ADDR_W'(((ch + 1) << BANK_AW) | w);
  endfunction

  function automatic logic [ADDR_W-1:0] adc_bus_addr(input int w);
    return ADDR_W'(((NUM_CH + 1) << BANK_AW) | w);
  endfunction

  // Bus helpers are entered and left one time unit after a rising edge.
  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    avs.address = a; avs.writedata = d; avs.byteenable = be;
    avs.chipselect = 1'b1; avs.write = 1'b1;
    @(posedge clk); #1;
    avs.chipselect = 1'b0; avs.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                          output logic rdv_first, output logic rdv_second);
    avs.address = a; avs.chipselect = 1'b1; avs.read = 1'b1;
    @(posedge clk); #1;
    avs.chipselect = 1'b0; avs.read = 1'b0;
    rdv_first = avs.readdatavalid;
    d = avs.readdata;
    @(posedge clk); #1;
    rdv_second = avs.readdatavalid;
  endtask

  task automatic load_word(input int ch, input int w, input logic [31:0] d);
    cpu_write(bank_addr(ch, w), d, 4'hF);
    for (int b = 0; b < 4; b++) model[ch][4*w + b] = d[8*b +: 8];
  endtask

  task automatic build_expect(input int vs, input int ve, input int rep);
    int passes;
    beat_t e;
    passes = (rep < 1) ? 1 : rep;
    for (int p = 0; p < passes; p++)
      for (int a = vs; a <= ve; a++) begin
        for (int c = 0; c < NUM_CH; c++) e.data[8*c +: 8] = model[c][a];
        e.last = (p == passes - 1) && (a == ve);
        exp_q.push_back(e);
      end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v1, v2;
    tests_run++;
    if (avs.readdatavalid !== 1'b0 || avs.readdata !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_bus: rdv=%b rd=%h required 0/0", avs.readdatavalid, avs.readdata);
    end
    tests_run++;
    if (seq_valid !== 1'b0 || seq_last !== 1'b0 || seq_data !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_seq: v=%b l=%b d=%h required 0", seq_valid, seq_last, seq_data);
    end
    tests_run++;
    if (tck_width !== 32'h0 || adc_config_even !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_regs: tck_width=%h cfg_even=%h required 0", tck_width, adc_config_even);
    end
    cpu_read(reg_addr(12), d, v1, v2);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_status: got %h required 0", d); end
    cpu_read(reg_addr(15), d, v1, v2);
    tests_run++;
    if (d !== 32'h4A564D02) begin tests_failed++; $display("[TB] FAIL id: got %h required 4a564d02", d); end
    cpu_read(reg_addr(13), d, v1, v2);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_cur_addr: got %h required 0", d); end
`ifdef JVM_IRQ_EN
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_irq: got %b required 0", irq); end
`endif
  endtask

  task automatic test_registers();
    logic [31:0] d; logic v1, v2;
    logic [31:0] vals [8];
    cpu_write(reg_addr(1), 32'h12345678, 4'b0101);
    tests_run++;
    if (tck_delay !== 32'h00340078) begin tests_failed++; $display("[TB] FAIL be_output: got %h required 00340078", tck_delay); end
    cpu_read(reg_addr(1), d, v1, v2);
    tests_run++;
    if (d !== 32'h00340078) begin tests_failed++; $display("[TB] FAIL be_read: got %h required 00340078", d); end
    tests_run++;
    if (v1 !== 1'b1 || v2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rdv_pulse: got %b%b required 10", v1, v2); end
    for (int r = 0; r < 8; r++) vals[r] = 32'hC0DE0000 + 32'(r) * 32'h00001111;
    vals[1] = 32'h00340078;
    for (int r = 0; r < 8; r++) if (r != 1) cpu_write(reg_addr(r), vals[r], 4'hF);
    for (int r = 0; r < 8; r++) begin
      cpu_read(reg_addr(r), d, v1, v2);
      tests_run++;
      if (d !== vals[r]) begin tests_failed++; $display("[TB] FAIL reg_rw[%0d]: got %h required %h", r, d, vals[r]); end
    end
    tests_run++;
    if (adc_config_odd !== vals[6] || tms_delay !== vals[2]) begin
      tests_failed++; $display("[TB] FAIL reg_outputs: odd=%h tms=%h required %h %h", adc_config_odd, tms_delay, vals[6], vals[2]);
    end
    cpu_read(reg_addr(11), d, v1, v2);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("[TB] FAIL ctrl_read: got %h required 0", d); end
    cpu_write(ADDR_W'(4 << BANK_AW), 32'h55555555, 4'hF);
    cpu_read(ADDR_W'(4 << BANK_AW), d, v1, v2);
    tests_run++;
    if (d !== 32'hDEADBEEF || v1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL unmapped: got %h rdv=%b required deadbeef 1", d, v1); end
  endtask

  // Streams one run; stall_at >= 0 drops seq_ready for 3 cycles after that many beats.
  task automatic test_sequencer_run(input int stall_at);
    logic [31:0] d; logic v1, v2;
    beat_t e;
    int cyc, accepted, stall_cnt;
    bit held;
    logic [8*NUM_CH-1:0] held_data;
    cyc = 0; accepted = 0; stall_cnt = 0; held = 0; held_data = '0;
    cpu_write(reg_addr(11), 32'h4, 4'hF);
    cpu_write(reg_addr(8), 32'd2, 4'hF);
    cpu_write(reg_addr(9), 32'd5, 4'hF);
    cpu_write(reg_addr(10), 32'd2, 4'hF);
    build_expect(2, 5, 2);
    cpu_write(reg_addr(11), 32'h1, 4'hF);
    while (exp_q.size() > 0 && cyc < 200) begin
      seq_ready = (stall_at < 0) || (accepted != stall_at) || (stall_cnt >= 3);
      if (!seq_ready) stall_cnt++;
      #4;
      if (held) begin
        tests_run++;
        if (seq_valid !== 1'b1 || seq_data !== held_data) begin
          tests_failed++; $display("[TB] FAIL stall_hold: v=%b d=%h required 1 %h", seq_valid, seq_data, held_data);
        end
      end
      held = 0;
      if (seq_valid === 1'b1) begin
        if (seq_ready) begin
          e = exp_q.pop_front();
          accepted++;
          tests_run++;
          if (seq_data !== e.data || seq_last !== e.last) begin
            tests_failed++;
            $display("[TB] FAIL beat[%0d]: got %h/%b required %h/%b", accepted, seq_data, seq_last, e.data, e.last);
          end
        end else begin
          held = 1; held_data = seq_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("[TB] FAIL stream_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if (seq_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL after_last_valid: got %b required 0", seq_valid); end
    cpu_read(reg_addr(12), d, v1, v2);
    tests_run++;
    if (d !== 32'h2) begin tests_failed++; $display("[TB] FAIL run_status: got %h required 2", d); end
    cpu_read(reg_addr(14), d, v1, v2);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("[TB] FAIL cur_pass: got %h required 1", d); end
  endtask

  task automatic test_illegal_range();
    logic [31:0] d; logic v1, v2;
    int seen;
    logic [31:0] ends [2];
    logic [31:0] starts [2];
    starts[0] = 32'd9; ends[0] = 32'd4;
    starts[1] = 32'd0; ends[1] = 32'd4096;
    seq_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_write(reg_addr(11), 32'h4, 4'hF);
      cpu_write(reg_addr(8), starts[k], 4'hF);
      cpu_write(reg_addr(9), ends[k], 4'hF);
      cpu_write(reg_addr(11), 32'h1, 4'hF);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        #4; if (seq_valid !== 1'b0) seen++;
        @(posedge clk); #1;
      end
      tests_run++;
      if (seen != 0) begin tests_failed++; $display("[TB] FAIL illegal_valid[%0d]: %0d valid cycles required 0", k, seen); end
      cpu_read(reg_addr(12), d, v1, v2);
      tests_run++;
      if (d !== 32'h4) begin tests_failed++; $display("[TB] FAIL illegal_status[%0d]: got %h required 4", k, d); end
`ifdef JVM_IRQ_EN
      tests_run++;
      if (irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_set[%0d]: got %b required 1", k, irq); end
`endif
    end
    cpu_write(reg_addr(11), 32'h4, 4'hF);
    cpu_read(reg_addr(12), d, v1, v2);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("[TB] FAIL clear_status: got %h required 0", d); end
`ifdef JVM_IRQ_EN
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL irq_clear: got %b required 0", irq); end
`endif
  endtask

  task automatic test_abort();
    logic [31:0] d; logic v1, v2;
    beat_t e;
    int cyc, accepted, seen;
    for (int w = 0; w < 25; w++) begin
      load_word(0, w, {8'(4*w+3) ^ 8'hA5, 8'(4*w+2) ^ 8'hA5, 8'(4*w+1) ^ 8'hA5, 8'(4*w) ^ 8'hA5});
      load_word(1, w, {8'(4*w+3) + 8'h40, 8'(4*w+2) + 8'h40, 8'(4*w+1) + 8'h40, 8'(4*w) + 8'h40});
    end
    cpu_write(reg_addr(8), 32'd0, 4'hF);
    cpu_write(reg_addr(9), 32'd99, 4'hF);
    cpu_write(reg_addr(10), 32'd1, 4'hF);
    build_expect(0, 99, 1);
    seq_ready = 1'b1;
    cpu_write(reg_addr(11), 32'h1, 4'hF);
    cyc = 0; accepted = 0;
    while (accepted < 3 && cyc < 50) begin
      #4;
      if (seq_valid === 1'b1) begin
        e = exp_q.pop_front();
        accepted++;
        tests_run++;
        if (seq_data !== e.data || seq_last !== e.last) begin
          tests_failed++; $display("[TB] FAIL abort_beat[%0d]: got %h/%b required %h/%b", accepted, seq_data, seq_last, e.data, e.last);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    seq_ready = 1'b0;
    tests_run++;
    if (accepted != 3) begin tests_failed++; $display("[TB] FAIL abort_timeout: %0d beats required 3", accepted); end
    cpu_read(reg_addr(12), d, v1, v2);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("[TB] FAIL busy_status: got %h required 1", d); end
    cpu_write(reg_addr(11), 32'h2, 4'hF);
    tests_run++;
    if (seq_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_valid: got %b required 0", seq_valid); end
    exp_q.delete();
    seq_ready = 1'b1;
    cpu_read(reg_addr(12), d, v1, v2);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_status: got %h required 0", d); end
    cpu_write(reg_addr(11), 32'h3, 4'hF);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      #4; if (seq_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    cpu_read(reg_addr(12), d, v1, v2);
    tests_run++;
    if (seen != 0 || d !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL start_abort_same: valid=%0d status=%h required 0 0", seen, d);
    end
  endtask

  task automatic test_adc_collision();
    logic [31:0] d; logic v1, v2;
    adc_we = 1'b1; adc_addr = 10'd7; adc_wr_data = 32'hCAFEF00D;
    avs.address = adc_bus_addr(7); avs.writedata = 32'h11111111; avs.byteenable = 4'hF;
    avs.chipselect = 1'b1; avs.write = 1'b1;
    @(posedge clk); #1;
    avs.chipselect = 1'b0; avs.write = 1'b0;
    adc_addr = 10'd9; adc_wr_data = 32'h99887766;
    @(posedge clk); #1;
    adc_we = 1'b0;
    cpu_write(adc_bus_addr(8), 32'h0BADF00D, 4'hF);
    cpu_read(adc_bus_addr(7), d, v1, v2);
    tests_run++;
    if (d !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL adc_collision: got %h required cafef00d", d); end
    cpu_read(adc_bus_addr(8), d, v1, v2);
    tests_run++;
    if (d !== 32'h0BADF00D) begin tests_failed++; $display("[TB] FAIL adc_cpu_write: got %h required 0badf00d", d); end
    cpu_read(adc_bus_addr(9), d, v1, v2);
    tests_run++;
    if (d !== 32'h99887766) begin tests_failed++; $display("[TB] FAIL adc_capture: got %h required 99887766", d); end
  endtask

  task automatic test_vector_bank();
    logic [31:0] d; logic v1, v2;
    load_word(0, 0, 32'h13121110);
    load_word(0, 1, 32'h17161514);
    load_word(1, 0, 32'h23222120);
    load_word(1, 1, 32'h27262524);
    cpu_read(bank_addr(0, 1), d, v1, v2);
    tests_run++;
    if (d !== 32'h17161514) begin tests_failed++; $display("[TB] FAIL bank0_read: got %h required 17161514", d); end
    cpu_read(bank_addr(1, 0), d, v1, v2);
    tests_run++;
    if (d !== 32'h23222120) begin tests_failed++; $display("[TB] FAIL bank1_read: got %h required 23222120", d); end
  endtask

  initial begin
    avs.address = '0; avs.chipselect = 1'b0; avs.read = 1'b0; avs.write = 1'b0;
    avs.byteenable = 4'h0; avs.writedata = '0;
    seq_ready = 1'b0; adc_we = 1'b0; adc_addr = '0; adc_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_registers();
    test_vector_bank();
    test_sequencer_run(-1);
    test_sequencer_run(3);
    test_illegal_range();
    test_abort();
    test_adc_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
